// File: rtl/canny_gaus_pm.sv
// canny_gaus_pm: 3x3 Gaussian smoothing stage for the Canny chain.
// The kernel is [1 2 1; 2 4 2; 1 2 1] / 16, with a fixed latency of 4 clk.
// The block owns two line buffers and a column/row tracker. Border pixels and
// bypass mode pass the window centre through unchanged. The filter/bypass
// mode is latched once per frame, at the rising edge of din_vs.
// Optional macro GAUS_ROUND_EN: add 8 before the final >>4 (round half up).
// When the macro is undefined, the result is truncated.
module canny_gaus_pm #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 1024,
    parameter int IMG_H  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_vld,
    input  logic              din_hs,
    input  logic              din_vs,
    input  logic [DATA_W-1:0] din,
    input  logic              gaus_en,
    output logic              dout_vld,
    output logic              dout_hs,
    output logic              dout_vs,
    output logic [DATA_W-1:0] dout
);

    localparam int CW = ($clog2(IMG_W) < 2) ? 2 : $clog2(IMG_W);
    localparam int RW = ($clog2(IMG_H) < 2) ? 2 : $clog2(IMG_H);
    localparam int SW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`ifdef GAUS_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(8);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    // Position tracking and frame state
    logic          vld_d, vs_d, frame_ok, mode_r, col_ovf;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Effective values for the pixel at the input this cycle
    logic          vs_rise, vld_fall, ovf_e, mode_e, border;
    logic [CW-1:0] col_e;
    logic [RW-1:0] row_e;

    // Line buffers: lb1 holds row r-1 and lb2 holds row r-2
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    // Window: a1..a3 are the top row (oldest column first), a4..a6 the middle
    // row and a7..a9 the bottom row
    logic [DATA_W-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic              byp_c1, byp_c2, byp_c3;
    logic [DATA_W+1:0] sum_t, sum_b;
    logic [DATA_W+2:0] sum_m;
    logic [SW-1:0]     total;
    logic [DATA_W-1:0] a5_c2, a5_c3;
    logic [3:0]        vld_sr, hs_sr, vs_sr;

    assign vs_rise  = din_vs & ~vs_d;
    assign vld_fall = ~din_vld & vld_d;

    // A frame start overrides the stale counters for the pixel that arrives
    // in the same cycle. Until the first frame start after reset, row reads
    // as 0 so that every pixel is treated as a border pixel.
    assign col_e  = vs_rise ? '0 : col;
    assign ovf_e  = vs_rise ? 1'b0 : col_ovf;
    assign row_e  = (vs_rise || !frame_ok) ? '0 : row;
    assign mode_e = vs_rise ? gaus_en : mode_r;
    assign border = (row_e < RW'(2)) | (col_e < CW'(2)) | ovf_e;

    assign lb1_rd = lb1[col_e];
    assign lb2_rd = lb2[col_e];

    // Edge history, frame-start handling, row counter and mode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d    <= 1'b0;
            vs_d     <= 1'b0;
            frame_ok <= 1'b0;
            mode_r   <= 1'b1;
            row      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every
            // block reads the pre-edge values regardless of block order.
            vld_d <= din_vld;
            vs_d  <= din_vs;
            if (vs_rise) begin
                frame_ok <= 1'b1;
                mode_r   <= gaus_en;
                row      <= '0;
            end else if (vld_fall && row != ROW_LAST) begin
                row <= row + RW'(1);
            end
        end
    end

    // Column counter: saturates at the last column, and flags pixels past it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            col_ovf <= 1'b0;
        end else if (din_vld) begin
            if (ovf_e || col_e == COL_LAST) begin
                col     <= COL_LAST;
                col_ovf <= 1'b1;
            end else begin
                col     <= col_e + CW'(1);
                col_ovf <= 1'b0;
            end
        end else begin
            col     <= '0;
            col_ovf <= 1'b0;
        end
    end

    // Line buffer update: the old lb1 word moves down into lb2 at the same column
    // NOTE: the RAM has no reset. Border masking keeps stale contents off dout.
    always_ff @(posedge clk) begin
        if (din_vld && !ovf_e) begin
            lb1[col_e] <= din;
            lb2[col_e] <= lb1_rd;
        end
    end

    // c1: shift the window by one column and register the bypass decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a1, a2, a3, a4, a5, a6, a7, a8, a9} <= '0;
            byp_c1 <= 1'b0;
        end else if (din_vld) begin
            a1 <= a2;  a2 <= a3;  a3 <= lb2_rd;
            a4 <= a5;  a5 <= a6;  a6 <= lb1_rd;
            a7 <= a8;  a8 <= a9;  a9 <= din;
            byp_c1 <= border | ~mode_e;
        end
    end

    // c2: weighted row sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_t  <= '0;
            sum_m  <= '0;
            sum_b  <= '0;
            a5_c2  <= '0;
            byp_c2 <= 1'b0;
        end else begin
            sum_t  <= {2'b00, a1} + {1'b0, a2, 1'b0} + {2'b00, a3};
            sum_m  <= {2'b00, a4, 1'b0} + {1'b0, a5, 2'b00} + {2'b00, a6, 1'b0};
            sum_b  <= {2'b00, a7} + {1'b0, a8, 1'b0} + {2'b00, a9};
            a5_c2  <= a5;
            byp_c2 <= byp_c1;
        end
    end

    // c3: kernel total, with the optional rounding constant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total  <= '0;
            a5_c3  <= '0;
            byp_c3 <= 1'b0;
        end else begin
            total  <= {2'b00, sum_t} + {1'b0, sum_m} + {2'b00, sum_b} + RND;
            a5_c3  <= a5_c2;
            byp_c3 <= byp_c2;
        end
    end

    // c4: divide by 16, or pass the delayed centre pixel through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= byp_c3 ? a5_c3 : DATA_W'(total >> 4);
        end
    end

    // Sync delay taps: shift every clock, matching the pixel latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else begin
            vld_sr <= {vld_sr[2:0], din_vld};
            hs_sr  <= {hs_sr[2:0], din_hs};
            vs_sr  <= {vs_sr[2:0], din_vs};
        end
    end

    assign dout_vld = vld_sr[3];
    assign dout_hs  = hs_sr[3];
    assign dout_vs  = vs_sr[3];

endmodule

// File: tb/tb_canny_gaus_pm.sv
// Testbench for canny_gaus_pm. Random and patterned frames are compared with
// a frame-level reference model (line buffers, a 3-column window, plain
// kernel arithmetic). A fixed 4-cycle expectation queue aligns the model
// with the DUT outputs.
module tb_canny_gaus_pm;

    localparam int DW   = 10;
    localparam int W    = 16;
    localparam int H    = 12;
    localparam int LAT  = 4;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_vld = 1'b0, din_hs = 1'b0, din_vs = 1'b0, gaus_en = 1'b1;
    logic [DW-1:0] din = '0;
    logic          dout_vld, dout_hs, dout_vs;
    logic [DW-1:0] dout;

    always #5 clk = ~clk;

    canny_gaus_pm #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_vld(din_vld), .din_hs(din_hs), .din_vs(din_vs), .din(din),
        .gaus_en(gaus_en),
        .dout_vld(dout_vld), .dout_hs(dout_hs), .dout_vs(dout_vs), .dout(dout)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit vld, hs, vs, chk;
        int dout, r, c, kind;
    } exp_t;
    exp_t q[$];

    // Reference model state. A value of -1 marks a pixel that is unknown
    // (for example, line-buffer contents from before the first write).
    int m_lb1 [W];
    int m_lb2 [W];
    int m_win [3][3];   // [column: 0 oldest .. 2 newest][row: 0 top .. 2 bottom]
    int m_col, m_row;
    bit m_ovf, m_prev_vld, m_prev_vs, m_frame_ok, m_mode;

    task automatic model_reset();
        m_col = 0; m_row = 0; m_ovf = 0;
        m_prev_vld = 0; m_prev_vs = 0; m_frame_ok = 0; m_mode = 1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) m_win[i][j] = 0;
    endtask

    function automatic int ref_filter();
        int wt [3] = '{1, 2, 1};
        int acc = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                if (m_win[i][j] < 0) return -1;
                acc += wt[i] * wt[j] * m_win[i][j];
            end
`ifdef GAUS_ROUND_EN
        acc += 8;
`endif
        return acc / 16;
    endfunction

    // Expected dout for the single-impulse frame (impulse 255 at (4,4))
    function automatic int imp_exp(input int r, input int c);
        int ro;
`ifdef GAUS_ROUND_EN
        ro = 1;
`else
        ro = 0;
`endif
        if (r == 5 && c == 5) return 63 + ro;
        if ((r == 5 && c == 6) || (r == 6 && c == 5)) return 31 + ro;
        if ((r == 5 && c == 4) || (r == 4 && c == 5)) return 31 + ro;
        if (r == 6 && c == 6) return 15 + ro;
        return -1;
    endfunction

    task automatic model_step(input bit v, input bit h, input bit s, input int d,
                              input bit en, input int r, input int c, input int kind);
        exp_t e;
        int   r1, r2, rr;
        bit   byp;
        e.vld = v; e.hs = h; e.vs = s; e.chk = 0; e.dout = 0;
        e.r = r; e.c = c; e.kind = kind;
        if (s && !m_prev_vs) begin
            m_col = 0; m_ovf = 0; m_row = 0; m_frame_ok = 1; m_mode = en;
        end else if (!v && m_prev_vld && m_row < H - 1) begin
            m_row++;
        end
        if (v) begin
            r1 = m_lb1[m_col];
            r2 = m_lb2[m_col];
            if (!m_ovf) begin
                m_lb2[m_col] = r1;
                m_lb1[m_col] = d;
            end
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 3; j++) m_win[i][j] = m_win[i+1][j];
            m_win[2][0] = r2;
            m_win[2][1] = r1;
            m_win[2][2] = d;
            rr  = m_frame_ok ? m_row : 0;
            byp = (rr < 2) || (m_col < 2) || m_ovf || !m_mode;
            e.dout = byp ? m_win[1][1] : ref_filter();
            e.chk  = (e.dout >= 0);
            if (m_ovf || m_col == W - 1) begin
                m_col = W - 1; m_ovf = 1;
            end else begin
                m_col++;
            end
        end else begin
            m_col = 0; m_ovf = 0;
        end
        m_prev_vld = v;
        m_prev_vs  = s;
        q.push_back(e);
    endtask

    // One clock: compare the outputs due now, then drive and model the next input
    task automatic tick(input bit v, input bit h, input bit s, input int d,
                        input bit en, input int r, input int c, input int kind);
        exp_t e;
        int   x;
        @(negedge clk);
        if (q.size() == LAT) begin
            e = q.pop_front();
            check("dout_vld", int'(dout_vld), int'(e.vld));
            check("dout_hs", int'(dout_hs), int'(e.hs));
            check("dout_vs", int'(dout_vs), int'(e.vs));
            if (e.vld && e.chk)
                check($sformatf("dout k%0d r%0d c%0d", e.kind, e.r, e.c), int'(dout), e.dout);
            if (e.vld && e.kind == 2) begin
                x = imp_exp(e.r, e.c);
                if (x >= 0) check($sformatf("impulse r%0d c%0d", e.r, e.c), int'(dout), x);
            end
        end
        din_vld = v; din_hs = h; din_vs = s; din = DW'(d); gaus_en = en;
        model_step(v, h, s, d, en, r, c, kind);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_dout"}, int'(dout), 0);
        check({tag, "_vld"}, int'(dout_vld), 0);
        check({tag, "_hs"}, int'(dout_hs), 0);
        check({tag, "_vs"}, int'(dout_vs), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        din_vld = 0; din_hs = 0; din_vs = 0;
        rst_n = 0;
        q.delete();
        model_reset();
        #1 chk_zero("rst_a");
        @(negedge clk);
        chk_zero("rst_b");
        @(negedge clk);
        chk_zero("rst_c");
        rst_n = 1;
    endtask

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            1:       return 100;
            2:       return (r == 4 && c == 4) ? 255 : 0;
            3:       return MAXV;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    task automatic send_frame(input int kind, input int w, input int h, input bit en0,
                              input int sw_row, input bit en1, input bit vs_pix,
                              input int rst_row);
        bit en;
        en = en0;
        if (!vs_pix) begin
            tick(0, 0, 1, 0, en, -1, -1, -1);
            tick(0, 0, 1, 0, en, -1, -1, -1);
            tick(0, 0, 0, 0, en, -1, -1, -1);
        end
        for (int r = 0; r < h; r++) begin
            if (r == rst_row) mid_reset();
            en = (r >= sw_row) ? en1 : en0;
            tick(0, 1, 0, 0, en, -1, -1, -1);
            tick(0, 0, 0, 0, en, -1, -1, -1);
            tick(0, 0, 0, 0, en, -1, -1, -1);
            for (int c = 0; c < w; c++)
                tick(1, 0, vs_pix && r == 0 && c == 0, pix(kind, r, c), en, r, c, kind);
        end
        repeat (4) tick(0, 0, 0, 0, en, -1, -1, -1);
    endtask

    initial begin
        for (int i = 0; i < W; i++) begin
            m_lb1[i] = -1;
            m_lb2[i] = -1;
        end
        model_reset();
        #12 chk_zero("por");
        @(negedge clk);
        chk_zero("por2");
        rst_n = 1;

        send_frame(0, 8, 8, 1, 99, 1, 0, -1);      // random, filtered
        send_frame(1, 8, 8, 1, 99, 1, 0, -1);      // flat 100
        send_frame(2, 8, 8, 1, 99, 1, 0, -1);      // single impulse
        send_frame(3, 8, 8, 1, 99, 1, 0, -1);      // all maximum
        send_frame(0, 10, 10, 1, 3, 0, 0, -1);     // gaus_en drops mid-frame
        send_frame(0, 10, 10, 0, 99, 0, 0, -1);    // bypass frame
        send_frame(0, W + 4, 6, 1, 99, 1, 0, -1);  // over-long lines
        send_frame(0, W, 6, 1, 99, 1, 0, -1);      // buffers still intact
        send_frame(0, 8, 8, 1, 99, 1, 0, 3);       // reset mid-frame
        send_frame(0, 8, 8, 1, 99, 1, 0, -1);      // filtered again
        send_frame(0, 8, 8, 1, 99, 1, 1, -1);      // frame start on first pixel
        repeat (LAT + 2) tick(0, 0, 0, 0, 1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
